// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared encodings for the data-memory load/store initiator:
//   access sizes, response error codes, FSM states, and the lane helpers
//   used to build byte enables and lane-replicated store data.
package mem_ctrl_pkg;

   // Access size in req_op[1:0]; 2'd3 is illegal and reported as misaligned.
   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_RANGE   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: byte_en = 4'b0001 << lo;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   // Sub-word store data is replicated to every lane so the responder
   // picks it up under whichever byte enables are active.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         SZ_HALF: lane_data = {2{wd[15:0]}};
         SZ_BYTE: lane_data = {4{wd[7:0]}};
         default: lane_data = wd;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_load_extract.sv
// load_extract
//   Combinational load formatter: picks the addressed byte or halfword out
//   of the full read word and sign- or zero-extends it to 32 bits.
//   op      [1:0] access size, [2] unsigned load
//   addr_lo byte offset within the word
//   rd      full read word from memory
//   data    extended load result
module load_extract
   import mem_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rd,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        sgn_b;
   logic        sgn_h;

   always_comb begin
      case (addr_lo)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h     = addr_lo[1] ? rd[31:16] : rd[15:0];
      sgn_b = b[7]  & ~op[2];
      sgn_h = h[15] & ~op[2];
      case (op[1:0])
         SZ_BYTE: data = {{24{sgn_b}}, b};
         SZ_HALF: data = {{16{sgn_h}}, h};
         default: data = rd;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Load/store initiator between the MEM stage and the data-memory
//   responder. One access at a time: IDLE accepts, BUS waits for mem_ack
//   (bounded by TIMEOUT cycles), RESP holds the result until consumed.
//   Optional build macro MEM_CTRL_TRACE_EN prints completed stores and
//   errors; behaviour is identical with or without it.
//
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_op, req_addr, req_wd   request side
//   resp_valid/resp_ready, resp_rdata, resp_err             response side
//   mem_req, mem_we, mem_be, mem_addr, mem_wd, mem_ack, mem_rd  memory bus
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_BEGIN = 32'h0000_0000,
   parameter logic [31:0] ADDR_END   = 32'h0000_2fff,
   parameter int          TIMEOUT    = 15,
   parameter int          TO_WIDTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic        mem_ack,
   input  logic [31:0] mem_rd
);

   localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT - 1);

   logic [1:0]          state;
   logic [TO_WIDTH-1:0] cnt;

   logic                we_q;
   logic [2:0]          op_q;
   logic [31:0]         addr_q;
   logic [31:0]         wd_q;
   logic [31:0]         rdata_q;
   logic [1:0]          err_q;

   logic                misalign;
   logic                out_range;
   logic                in_bus;
   logic                to_last;
   logic [31:0]         ext_data;

   always_comb begin
      misalign = (req_op[1:0] == 2'd3) ||
                 ((req_op[1:0] == SZ_HALF) && req_addr[0]) ||
                 ((req_op[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00));
      // Single unsigned compare covers both bounds: addresses below
      // ADDR_BEGIN wrap to large offsets.
      out_range = (req_addr - ADDR_BEGIN) > (ADDR_END - ADDR_BEGIN);
   end

   assign in_bus  = (state == ST_BUS);
   assign to_last = (cnt == CNT_LAST);

   load_extract u_load_extract (
      .op      (op_q),
      .addr_lo (addr_q[1:0]),
      .rd      (mem_rd),
      .data    (ext_data)
   );

   // Control: FSM and timeout counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state <= (misalign || out_range) ? ST_RESP : ST_BUS;
                  cnt   <= '0;
               end
            end
            ST_BUS: begin
               // Ack in the final cycle still completes normally.
               if (mem_ack || to_last) state <= ST_RESP;
               else                    cnt   <= cnt + 1'b1;
            end
            ST_RESP: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Data: request capture and response payload (outputs are gated by state)
   always_ff @(posedge clk) begin
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               we_q    <= req_we;
               op_q    <= req_op;
               addr_q  <= req_addr;
               wd_q    <= req_wd;
               rdata_q <= '0;
               err_q   <= misalign  ? ERR_ALIGN :
                          out_range ? ERR_RANGE : ERR_NONE;
            end
         end
         ST_BUS: begin
            if (mem_ack) begin
               rdata_q <= we_q ? 32'd0 : ext_data;
               err_q   <= ERR_NONE;
            end else if (to_last) begin
               err_q   <= ERR_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      resp_rdata = resp_valid ? rdata_q : 32'd0;
      resp_err   = resp_valid ? err_q   : ERR_NONE;
      mem_req    = in_bus;
      mem_we     = in_bus & we_q;
      mem_be     = in_bus ? byte_en(op_q[1:0], addr_q[1:0])   : 4'd0;
      mem_addr   = in_bus ? {addr_q[31:2], 2'b00}             : 32'd0;
      mem_wd     = in_bus ? lane_data(op_q[1:0], wd_q)        : 32'd0;
   end

`ifdef MEM_CTRL_TRACE_EN
   always @(posedge clk) begin
      if (reset) begin
         if (in_bus && mem_ack && we_q)
            $display("%0t mem_ctrl store addr=%h be=%b wd=%h", $time, mem_addr, mem_be, mem_wd);
         if ((state == ST_IDLE) && req_valid && (misalign || out_range))
            $display("%0t mem_ctrl error err=%0d addr=%h", $time,
                     misalign ? ERR_ALIGN : ERR_RANGE, req_addr);
         if (in_bus && !mem_ack && to_last)
            $display("%0t mem_ctrl error err=%0d addr=%h", $time, ERR_TIMEOUT, addr_q);
      end
   end
`else
   // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

   localparam logic [31:0] A_END = 32'h0000_2fff;
   localparam int          TO    = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wd;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   mem_ctrl #(.ADDR_BEGIN(32'h0), .ADDR_END(A_END), .TIMEOUT(TO), .TO_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wd(req_wd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_ack(mem_ack), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wd; logic [31:0] rd; int d; } plan_t;
   typedef struct { logic [31:0] rdata; logic [1:0] err; } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    force_hold = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'd0: return 4;
         2'd1: return 2;
         2'd2: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1:0] model_err(input logic [1:0] sz, input logic [31:0] addr, input int d);
      int n = nbytes(sz);
      if (n == 0 || (addr % n) != 0) return 2'd1;
      if (addr > A_END)              return 2'd2;
      if (d >= TO)                   return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_rdata(input logic we, input logic [2:0] op,
                                               input logic [31:0] addr, input logic [31:0] rd);
      int bits;
      logic [63:0] v;
      if (we) return 32'd0;
      bits = 8 * nbytes(op[1:0]);
      v = (64'(rd) >> (8 * (addr % 4))) & ((64'd1 << bits) - 64'd1);
      if (!op[2] && v[bits-1]) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
      logic [7:0] m;
      m = ((8'd1 << nbytes(sz)) - 8'd1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
      case (nbytes(sz))
         2: return (wd & 32'h0000ffff) * 32'h00010001;
         1: return (wd & 32'h000000ff) * 32'h01010101;
         default: return wd;
      endcase
   endfunction

   // ---------------- memory responder / bus checker ----------------
   initial begin : responder
      bit    active;
      int    n;
      int    exp_n;
      plan_t p;
      active = 0; n = 0;
      mem_ack = 1'b0; mem_rd = 32'd0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            active = 0; mem_ack = 1'b0;
         end else if (mem_req) begin
            if (!active) begin
               chk("plan_q_depth", plan_q.size(), 1);
               if (plan_q.size() > 0) p = plan_q.pop_front();
               else p = '{we: 1'b0, be: 4'd0, addr: 32'd0, wd: 32'd0, rd: 32'd0, d: 1000};
               chk("mem_addr", mem_addr, p.addr);
               chk("mem_be", 32'(mem_be), 32'(p.be));
               chk("mem_we", 32'(mem_we), 32'(p.we));
               if (p.we) chk("mem_wd", mem_wd, p.wd);
               active = 1; n = 0;
            end
            n++;
            if (n == TO + 1) chk("mem_req_overrun", n, TO);
            if (n - 1 == p.d) begin mem_ack = 1'b1; mem_rd = p.rd; end
            else begin mem_ack = 1'b0; mem_rd = $urandom; end
         end else begin
            if (active) begin
               exp_n = (p.d < TO) ? p.d + 1 : TO;
               chk("mem_req_cycles", n, exp_n);
               active = 0;
            end
            // Spurious acks outside BUS must be ignored.
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rd  = $urandom;
         end
      end
   end

   // ---------------- response monitor / scoreboard ----------------
   initial begin : monitor
      bit   busy;
      int   hold;
      exp_t e;
      busy = 0; hold = 0; resp_ready = 1'b0;
      e = '{rdata: 32'd0, err: 2'd0};
      forever begin
         @(negedge clk);
         if (reset && resp_valid) begin
            if (!busy) begin
               chk("resp_q_depth", exp_q.size(), 1);
               if (exp_q.size() > 0) e = exp_q.pop_front();
               busy = 1;
               hold = (force_hold > 0) ? force_hold :
                      (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            resp_ready = (hold == 0);
            if (hold > 0) hold--;
            if (resp_ready) busy = 0;
         end else begin
            resp_ready = 1'b0;
            if (!reset) busy = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int d, input logic [31:0] rd, input int hold);
      exp_t  e;
      plan_t p;
      int    t;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("wait_req_ready", 32'(req_ready), 32'd1);
      e.err   = model_err(op[1:0], addr, d);
      e.rdata = (e.err != 2'd0) ? 32'd0 : model_rdata(we, op, addr, rd);
      force_hold = hold;
      exp_q.push_back(e);
      if (e.err == 2'd0 || e.err == 2'd3) begin
         p.we = we; p.be = model_be(op[1:0], addr); p.addr = addr & 32'hffff_fffc;
         p.wd = model_wd(op[1:0], wd); p.rd = rd; p.d = d;
         plan_q.push_back(p);
      end
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wd = wd;
      @(posedge clk); #1;
      if (e.err == 2'd1 || e.err == 2'd2) begin
         chk("err_path_resp_valid", 32'(resp_valid), 32'd1);
         chk("err_path_no_mem_req", 32'(mem_req), 32'd0);
      end else begin
         chk("bus_mem_req", 32'(mem_req), 32'd1);
         chk("bus_no_resp", 32'(resp_valid), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0; req_we = $urandom; req_op = $urandom; req_addr = $urandom; req_wd = $urandom;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t;
      logic [1:0]  sz;
      logic [31:0] a;
      int          d;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wd = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Directed cases
      issue(1'b0, 3'b010, 32'h0003, 32'd0, 0, 32'h80112233, 0);   // LB
      issue(1'b0, 3'b110, 32'h0003, 32'd0, 0, 32'h80112233, 0);   // LBU
      issue(1'b1, 3'b001, 32'h0102, 32'h0000beef, 0, 32'h12345678, 0); // SH
      issue(1'b0, 3'b000, 32'h0006, 32'd0, 0, 32'd0, 0);          // misaligned LW
      issue(1'b0, 3'b000, 32'h3000, 32'd0, 0, 32'd0, 0);          // out of range LW
      issue(1'b0, 3'b000, 32'h0100, 32'd0, 100, 32'hdeadbeef, 0); // timeout
      issue(1'b0, 3'b000, 32'h0104, 32'd0, 14, 32'hcafef00d, 0);  // ack on last cycle
      issue(1'b0, 3'b001, 32'h0002, 32'd0, 1, 32'h8001_7fff, 0);  // LH upper half
      issue(1'b0, 3'b101, 32'h0002, 32'd0, 2, 32'h8001_7fff, 0);  // LHU upper half

      // Long response hold with a competing request during RESP
      issue(1'b0, 3'b000, 32'h0200, 32'd0, 0, 32'h0badf00d, 5);
      t = 0;
      while (!resp_valid && t < 40) begin @(negedge clk); t++; end
      chk("hold_resp_seen", 32'(resp_valid), 32'd1);
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0300;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("resp_held_valid", 32'(resp_valid), 32'd1);
         chk("no_accept_in_resp", 32'(mem_req), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      force_hold = 0;

      // Reset in the middle of a bus access
      issue(1'b0, 3'b000, 32'h0010, 32'd0, 100, 32'd0, 0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midbus_rst_mem_req", 32'(mem_req), 32'd0);
      chk("midbus_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midbus_rst_req_ready", 32'(req_ready), 32'd1);
      chk("midbus_rst_mem_addr", mem_addr, 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      issue(1'b0, 3'b000, 32'h0020, 32'd0, 0, 32'h13579bdf, 0);

      // Randomised traffic
      for (int i = 0; i < 150; i++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       a = 32'h3000 + $urandom_range(0, 255);
            1:       a = $urandom;
            default: a = $urandom_range(0, 32'h2fff);
         endcase
         if (sz != 2'd3 && $urandom_range(0, 4) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
         case ($urandom_range(0, 9))
            0:       d = 14;
            1:       d = $urandom_range(15, 20);
            default: d = $urandom_range(0, 3);
         endcase
         issue(1'($urandom), {1'($urandom), sz}, a, $urandom, d, $urandom, 0);
      end

      t = 0;
      while ((exp_q.size() != 0 || resp_valid || mem_req) && t < 200) begin @(negedge clk); t++; end
      chk("drain_resp_q", exp_q.size(), 0);
      chk("drain_plan_q", plan_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store initiator between the pipeline MEM stage and the data-memory responder. Accepts one access per handshake, checks alignment and address range, drives a word-aligned request with byte enables and lane-shifted store data, waits for the memory acknowledge with a timeout, and returns sign/zero-extended load data or an error code. It is the requesting end of the data-memory interface.

## Interface
- ADDR_BEGIN, 0, lowest legal byte address (inclusive)
- ADDR_END, 'h2fff, highest legal byte address (inclusive)
- TIMEOUT, 15, BUS-state cycles without mem_ack before a timeout error (1..2^TO_WIDTH-1)
- TO_WIDTH, 4, timeout counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  [1:0] size: 0 word, 1 half, 2 byte (3 illegal → misaligned error); [2] unsigned load (ignored for stores)
- req_addr  in  32  byte address
- req_wd  in  32  store data, right-aligned
- resp_valid  out  1  response available; held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  0 ok, 1 misaligned, 2 out of range, 3 timeout
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  store
- mem_be  out  4  byte enables
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wd  out  32  store data shifted to its lane
- mem_ack  in  1  responder done; mem_rd valid in the same cycle
- mem_rd  in  32  full read word

## Operation
- FSM: IDLE, BUS, RESP. Request fields registered at acceptance (req_valid && req_ready).
- IDLE → RESP with error if misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 3) or out of range (addr < ADDR_BEGIN or addr > ADDR_END); misaligned outranks out of range. No mem_req issued.
- IDLE → BUS otherwise; timeout counter cleared.
- BUS: mem_req=1. On mem_ack: capture result, → RESP, err 0. Otherwise counter increments; ack absent while counter == TIMEOUT-1 → RESP, err 3. Ack on the final cycle wins over timeout.
- RESP: resp_valid=1, outputs stable; on resp_ready → IDLE.
- Byte enables: word 4'b1111; half addr[1]?4'b1100:4'b0011; byte 4'b0001 << addr[1:0]. mem_wd = byte/half data replicated to all lanes; word passes unchanged.
- Load extract: select byte lane addr[1:0] or half lane addr[1]; sign-extend unless op[2].
- mem_we, mem_be, mem_addr, mem_wd are valid only while mem_req=1; they are 0 otherwise.

## Timing
- Reset (async): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, all mem_* outputs 0, counter 0. Reset mid-BUS drops mem_req immediately; the access is abandoned.
- Accept at edge E0 → mem_req high in the cycle after E0. If mem_ack is in that cycle → resp_valid after E1 → IDLE after the resp_ready edge E2. Minimum 3 cycles per access, no overlap.
- Error path: accept at E0 → resp_valid after E0.
- Timeout: mem_req high exactly TIMEOUT cycles, then resp_valid with err 3.
- req_valid is ignored outside IDLE. mem_ack is ignored outside BUS.

## Configuration
- MEM_CTRL_TRACE_EN defined: on each successful store completion, $display of time, registered pc-free address {addr[31:2],2'b00}, mem_be, and mem_wd; on each error, $display of err code and address. Undefined: no simulation output, identical RTL behaviour.

## Structure
- Package mem_ctrl_pkg: size encodings (SZ_WORD/SZ_HALF/SZ_BYTE), error codes (ERR_NONE/ERR_ALIGN/ERR_RANGE/ERR_TIMEOUT), FSM state encoding.
- Sub-module load_extract: combinational (op, addr[1:0], mem_rd) → 32-bit extended data; instantiated once.

## Test plan
- LB at 'h0003, mem_rd='h80112233, ack on first BUS cycle → resp_rdata='hffffff80, err 0. LBU same → 'h00000080.
- SH at 'h0102, req_wd='h0000beef → mem_be=4'b1100, mem_addr='h0100, mem_wd='hbeefbeef, resp_rdata=0.
- LW at 'h0006 → resp_valid the cycle after acceptance, err 1, mem_req never high. LW at 'h3000 → err 2.
- mem_ack held low → mem_req high exactly 15 cycles, then err 3. Ack on cycle 15 → err 0.
- reset driven low while in BUS → mem_req and resp_valid 0 immediately; after release req_ready=1 and the next LW completes normally.
- resp_ready held low 5 cycles → resp_valid and resp_rdata stable; req_valid during RESP not accepted.
